// File: rtl/tour_cmd_seq.sv
// Knight's-tour replay sequencer: turns each stored one-hot move into a
// vertical-then-horizontal pair of motion commands with a ready/accept handshake.
//
// state  | meaning
// IDLE   | waiting for start_tour
// VERT   | vertical leg command offered (cmd_rdy high)
// WAIT_V | vertical leg accepted, waiting for execution response
// HORZ   | horizontal leg command offered (cmd_rdy high)
// WAIT_H | horizontal leg accepted, waiting for response, then next move
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_done,
  output logic        tour_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] WAIT_H = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  logic [2:0]  state, nxt_state;
  logic [4:0]  nxt_indx;
  logic        move_ok, last_mv;
  logic        dy_pos, dy_two, dx_neg, dx_two;
  logic [15:0] vert_cmd, horz_cmd;

  assign move_ok = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
  assign last_mv = (mv_indx == LAST_IDX);

  // Per-bit masks derived from the move table; only valid when move is one-hot.
  assign dy_pos = |(move & 8'b1000_0111);
  assign dy_two = |(move & 8'b0011_0011);
  assign dx_neg = |(move & 8'b0001_1110);
  assign dx_two = |(move & 8'b1100_1100);

  assign vert_cmd = {4'h2, (dy_pos ? 8'h00 : 8'h7F), (dy_two ? 4'd2 : 4'd1)};
  assign horz_cmd = {4'h3, (dx_neg ? 8'h3F : 8'hBF), (dx_two ? 4'd2 : 4'd1)};

  always_comb begin
    nxt_state = state;
    nxt_indx  = mv_indx;
    cmd       = 16'h0000;
    cmd_rdy   = 1'b0;
    resp      = 8'hA5;
    tour_done = 1'b0;
    tour_err  = 1'b0;
    case (state)
      IDLE: begin
        if (start_tour) begin
          nxt_indx  = 5'd0;
          nxt_state = VERT;
        end
      end
      VERT: begin
        if (move_ok) begin
          cmd     = vert_cmd;
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) nxt_state = WAIT_V;
        end else begin
          tour_err  = 1'b1;
          nxt_state = IDLE;
        end
      end
      WAIT_V: begin
        if (send_resp) nxt_state = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt_state = WAIT_H;
      end
      WAIT_H: begin
        if (last_mv) resp = 8'h5A;
        if (send_resp) begin
          if (last_mv) begin
            tour_done = 1'b1;
            nxt_state = IDLE;
          end else begin
            nxt_indx  = mv_indx + 5'd1;
            nxt_state = VERT;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
    end else begin
      state   <= nxt_state;
      mv_indx <= nxt_indx;
    end
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: table of per-move expected commands driven
// through full replays, plus hold, illegal-move and mid-replay reset sequences.
module tb_tour_cmd_seq;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] v;
    logic [15:0] h;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp;
  logic        tour_done;
  logic        tour_err;

  vec_t        tbl [8];
  logic        bad_en = 1'b0;
  logic [4:0]  bad_idx = 5'd0;
  logic [7:0]  bad_val = 8'h00;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          acc_cnt = 0;

  tour_cmd_seq #(.NUM_MOVES(24)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp), .tour_done(tour_done), .tour_err(tour_err)
  );

  always #5 clk = ~clk;

  // Stored tour: move i is one-hot bit (i mod 8), optionally overridden with a bad code.
  always_comb begin
    move = tbl[mv_indx[2:0]].mv;
    if (bad_en && (mv_indx == bad_idx)) move = bad_val;
  end

  always @(posedge clk) begin
    if (tour_done) done_cnt <= done_cnt + 1;
    if (tour_err) err_cnt <= err_cnt + 1;
    if (cmd_rdy && clr_cmd_rdy) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start();
    start_tour = 1'b1;
    step();
    start_tour = 1'b0;
  endtask

  // Consumer for one move; called at a negedge with the DUT in VERT.
  task automatic do_move(input int i, input bit last, input bit hold, input bit both);
    vec_t e;
    e = tbl[i % 8];
    chk("v_rdy", cmd_rdy, 1);
    chk("v_cmd", cmd, e.v);
    chk("v_idx", mv_indx, i);
    chk("v_resp", resp, 8'hA5);
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        start_tour = (k == 4);
        step();
        start_tour = 1'b0;
        chk("hold_rdy", cmd_rdy, 1);
        chk("hold_cmd", cmd, e.v);
        chk("hold_idx", mv_indx, i);
      end
    end
    clr_cmd_rdy = 1'b1;
    send_resp = both;
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    chk("wv_rdy", cmd_rdy, 0);
    if (both) begin
      step();
      chk("wv_stay", cmd_rdy, 0);
    end
    send_resp = 1'b1;
    step();
    send_resp = 1'b0;
    chk("h_rdy", cmd_rdy, 1);
    chk("h_cmd", cmd, e.h);
    chk("h_idx", mv_indx, i);
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk("wh_rdy", cmd_rdy, 0);
    chk("wh_resp", resp, last ? 8'h5A : 8'hA5);
    send_resp = 1'b1;
    #1;
    chk("wh_done", tour_done, last);
    step();
    send_resp = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h01, 16'h2002, 16'h3BF1};
    tbl[1] = '{8'h02, 16'h2002, 16'h33F1};
    tbl[2] = '{8'h04, 16'h2001, 16'h33F2};
    tbl[3] = '{8'h08, 16'h27F1, 16'h33F2};
    tbl[4] = '{8'h10, 16'h27F2, 16'h33F1};
    tbl[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    tbl[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    tbl[7] = '{8'h80, 16'h2001, 16'h3BF2};

    // Reset values
    @(negedge clk);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_idx", mv_indx, 0);
    chk("rst_resp", resp, 8'hA5);
    chk("rst_done", tour_done, 0);
    chk("rst_err", tour_err, 0);
    step();
    rst_n = 1'b1;
    // Handshake inputs in IDLE must not start anything
    clr_cmd_rdy = 1'b1;
    send_resp = 1'b1;
    step();
    step();
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    step();
    chk("idle_rdy", cmd_rdy, 0);
    chk("idle_cmd", cmd, 16'h0000);

    // Full replay with hold at move 0 and simultaneous clr/send at move 2
    acc_cnt = 0;
    done_cnt = 0;
    start();
    for (int i = 0; i < 24; i++) do_move(i, i == 23, i == 0, i == 2);
    chk("full_idle_rdy", cmd_rdy, 0);
    chk("full_idle_cmd", cmd, 16'h0000);
    chk("full_acc", acc_cnt, 48);
    chk("full_done", done_cnt, 1);
    step();
    chk("post_rdy", cmd_rdy, 0);

    // Illegal move 8'h03 at index 5
    bad_en = 1'b1;
    bad_idx = 5'd5;
    bad_val = 8'h03;
    err_cnt = 0;
    start();
    for (int i = 0; i < 5; i++) do_move(i, 1'b0, 1'b0, 1'b0);
    chk("bad_idx", mv_indx, 5);
    chk("bad_rdy", cmd_rdy, 0);
    chk("bad_err", tour_err, 1);
    step();
    chk("bad_err_pulse", tour_err, 0);
    chk("bad_idle_rdy", cmd_rdy, 0);
    chk("bad_idle_cmd", cmd, 16'h0000);
    step();
    chk("bad_err_cnt", err_cnt, 1);

    // Zero move at index 0
    bad_idx = 5'd0;
    bad_val = 8'h00;
    start();
    chk("zero_rdy", cmd_rdy, 0);
    chk("zero_err", tour_err, 1);
    step();
    chk("zero_idle", cmd_rdy, 0);
    bad_en = 1'b0;

    // Asynchronous reset while in WAIT_H at index 12
    start();
    for (int i = 0; i < 12; i++) do_move(i, 1'b0, 1'b0, 1'b0);
    chk("r12_idx", mv_indx, 12);
    clr_cmd_rdy = 1'b1;
    step();
    send_resp = 1'b1;
    clr_cmd_rdy = 1'b0;
    step();
    send_resp = 1'b0;
    clr_cmd_rdy = 1'b1;
    step();
    clr_cmd_rdy = 1'b0;
    chk("r12_wh_rdy", cmd_rdy, 0);
    chk("r12_wh_idx", mv_indx, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_idx", mv_indx, 0);
    chk("ar_rdy", cmd_rdy, 0);
    chk("ar_cmd", cmd, 16'h0000);
    chk("ar_resp", resp, 8'hA5);
    chk("ar_done", tour_done, 0);
    chk("ar_err", tour_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("ar_quiet", cmd_rdy, 0);
    start();
    chk("re_idx", mv_indx, 0);
    chk("re_rdy", cmd_rdy, 1);
    chk("re_cmd", cmd, tbl[0].v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
